// File: rtl/packed_lane_unloader.sv
// Drains one packed frame (lanes 0..count-1) as a stream of single words.
// Valid/ready on both sides, one frame in flight, one idle bubble between frames.
module packed_lane_unloader #(
    parameter int WIDTH = 32,
    parameter int LANES = 16,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LANES-1:0] in_data,
    input  logic [CNT_W-1:0]       in_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [LANES-1:0][WIDTH-1:0]   store_q, store_d;
    logic [CNT_W-1:0]              eff_q, eff_d;
    logic [CNT_W-1:0]              idx_q, idx_d;
    logic                          out_valid_q, out_valid_d;
    logic [WIDTH-1:0]              out_data_q, out_data_d;
    logic [CNT_W-1:0]              out_index_q, out_index_d;
    logic                          out_last_q, out_last_d;
    logic [15:0]                   frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0]              eff_s;
    logic [CNT_W-1:0]              idx_next_s;

    // Clamp the requested count so lanes beyond LANES are never addressed.
    always_comb begin
        if (in_count > CNT_W'(LANES)) begin
            eff_s = CNT_W'(LANES);
        end else begin
            eff_s = in_count;
        end
        idx_next_s = idx_q + CNT_W'(1);
    end

    // Next-state and registered-output computation for the IDLE/SEND machine.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        eff_d       = eff_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    store_d = in_data;
                    eff_d   = eff_s;
                    if (eff_s == CNT_W'(0)) begin
                        // Empty frame completes immediately without a beat.
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d     = S_SEND;
                        idx_d       = CNT_W'(0);
                        out_valid_d = 1'b1;
                        out_data_d  = in_data[WIDTH-1:0];
                        out_index_d = CNT_W'(0);
                        out_last_d  = (eff_s == CNT_W'(1));
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d       = idx_next_s;
                        out_data_d  = store_q[idx_next_s[IDX_W-1:0]];
                        out_index_d = idx_next_s;
                        out_last_d  = (idx_next_s == (eff_q - CNT_W'(1)));
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State, frame store and output registers; async reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            store_q     <= '0;
            eff_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            eff_q       <= eff_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_SEND);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_packed_lane_unloader.sv
// Bench for packed_lane_unloader: queue-based beat model, frame table, corner sequences, random run.
module tb_packed_lane_unloader;

    localparam int WIDTH = 32;
    localparam int LANES = 16;
    localparam int CNT_W = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*LANES-1:0] in_data;
    logic [CNT_W-1:0]       in_count;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [CNT_W-1:0]       out_index;
    logic                   out_last;
    logic                   busy;
    logic [15:0]            frame_cnt;

    packed_lane_unloader #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          last;
    } beat_t;

    typedef struct {
        logic [4:0] cnt;
        int         stall;
        int         exp_beats;
        int         exp_last;
    } vec_t;

    beat_t       exp_q[$];
    logic [15:0] m_fc;
    int          m_acc;
    int          checks   = 0;
    int          failures = 0;
    int          beats_seen;
    int          last_idx_seen;
    int          ov_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH*LANES-1:0] rand_frame();
        logic [WIDTH*LANES-1:0] r;
        for (int i = 0; i < LANES; i++) r[WIDTH*i +: WIDTH] = $urandom;
        return r;
    endfunction

    // Reference: a frame becomes a queue of beats; one beat leaves per ready edge.
    task automatic model_edge();
        int    eff;
        beat_t b;
        if (exp_q.size() == 0) begin
            if (in_valid) begin
                m_acc++;
                eff = (int'(in_count) > LANES) ? LANES : int'(in_count);
                if (eff == 0) m_fc = m_fc + 16'd1;
                for (int i = 0; i < eff; i++) begin
                    b.data = in_data[WIDTH*i +: WIDTH];
                    b.idx  = i;
                    b.last = (i == eff - 1);
                    exp_q.push_back(b);
                end
            end
        end else if (out_ready) begin
            b = exp_q.pop_front();
            if (b.last) m_fc = m_fc + 16'd1;
        end
    endtask

    task automatic check_outputs();
        bit act_busy;
        act_busy = (exp_q.size() != 0);
        chk("in_ready", 64'(in_ready), 64'(!act_busy));
        chk("busy", 64'(busy), 64'(act_busy));
        chk("out_valid", 64'(out_valid), 64'(act_busy));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_fc));
        if (act_busy) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].data));
            chk("out_index", 64'(out_index), 64'(exp_q[0].idx));
            chk("out_last", 64'(out_last), 64'(exp_q[0].last));
        end
    endtask

    task automatic cycle(input bit do_chk);
        if (out_valid && out_ready) begin
            beats_seen++;
            last_idx_seen = int'(out_index);
        end
        if (out_valid) ov_seen++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (do_chk) check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_fc = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [4:0] cnt, input int stall);
        int left;
        int guard;
        left      = stall;
        guard     = 0;
        in_valid  = 1'b1;
        in_count  = cnt;
        in_data   = rand_frame();
        out_ready = 1'b1;
        cycle(1'b1);
        in_valid = 1'b0;
        while (exp_q.size() != 0) begin
            in_data = rand_frame();
            if (exp_q[0].idx == 1 && left > 0) begin
                out_ready = 1'b0;
                left--;
            end else begin
                out_ready = 1'b1;
            end
            cycle(1'b1);
            guard++;
            if (guard > 60) begin
                chk("drain_timeout", 64'(guard), 64'd0);
                exp_q.delete();
            end
        end
    endtask

    vec_t vecs[7];
    int   pat[$];

    initial begin
        vecs[0] = '{5'd3,  0, 3,  2};
        vecs[1] = '{5'd0,  0, 0, -1};
        vecs[2] = '{5'd20, 0, 16, 15};
        vecs[3] = '{5'd16, 2, 16, 15};
        vecs[4] = '{5'd1,  0, 1,  0};
        vecs[5] = '{5'd31, 0, 16, 15};
        vecs[6] = '{5'd5,  3, 5,  4};

        in_valid = 1'b0; in_count = '0; in_data = '0; out_ready = 1'b0;
        m_fc = 16'd0; m_acc = 0; beats_seen = 0; last_idx_seen = -1; ov_seen = 0;
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        // Spec frame A0/B1/C2 with a 4-cycle stall on beat 1 while in_data churns.
        in_valid = 1'b1; in_count = 5'd3; out_ready = 1'b0;
        in_data = '0;
        in_data[31:0] = 32'hA0; in_data[63:32] = 32'hB1; in_data[95:64] = 32'hC2;
        cycle(1'b1);
        in_valid = 1'b0; in_data = rand_frame(); out_ready = 1'b1;
        chk("ex_beat0", 64'(out_data), 64'hA0);
        chk("ex_idx0", 64'(out_index), 64'd0);
        chk("ex_last0", 64'(out_last), 64'd0);
        cycle(1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = rand_frame();
            in_valid = 1'b1;
            cycle(1'b1);
            chk("ex_stall_data", 64'(out_data), 64'hB1);
            chk("ex_stall_idx", 64'(out_index), 64'd1);
            chk("ex_stall_rdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(1'b1);
        chk("ex_beat2", 64'(out_data), 64'hC2);
        chk("ex_last2", 64'(out_last), 64'd1);
        cycle(1'b1);
        chk("ex_done_valid", 64'(out_valid), 64'd0);
        chk("ex_frame_cnt", 64'(frame_cnt), 64'd1);

        // Frame table: beat count and final index per clamped count.
        for (int v = 0; v < 7; v++) begin
            beats_seen = 0; last_idx_seen = -1;
            send_frame(vecs[v].cnt, vecs[v].stall);
            cycle(1'b1);
            chk("tbl_beats", 64'(beats_seen), 64'(vecs[v].exp_beats));
            chk("tbl_last_idx", 64'(last_idx_seen), 64'(vecs[v].exp_last));
        end

        // Back-to-back frames with in_valid held: exactly one idle cycle between them.
        m_acc = 0; pat.delete();
        in_valid = 1'b1; in_count = 5'd2; in_data = rand_frame(); out_ready = 1'b1;
        cycle(1'b1);
        pat.push_back(int'(out_valid));
        in_count = 5'd3; in_data = rand_frame();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            pat.push_back(int'(out_valid));
            if (m_acc >= 2) in_valid = 1'b0;
        end
        begin
            int first, last, zeros;
            first = -1; last = -1; zeros = 0;
            for (int i = 0; i < pat.size(); i++) if (pat[i] == 1) begin
                if (first < 0) first = i;
                last = i;
            end
            for (int i = first; i <= last; i++) if (pat[i] == 0) zeros++;
            chk("b2b_bubble", 64'(zeros), 64'd1);
            chk("b2b_beats", 64'(last - first + 1 - zeros), 64'd5);
        end

        // Asynchronous reset after beat 2 of 5.
        in_valid = 1'b1; in_count = 5'd5; in_data = rand_frame(); out_ready = 1'b1;
        cycle(1'b1);
        in_valid = 1'b0;
        cycle(1'b1);
        cycle(1'b1);
        chk("mid_idx", 64'(out_index), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_fc", 64'(frame_cnt), 64'd0);
        exp_q.delete(); m_fc = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        beats_seen = 0; last_idx_seen = -1;
        send_frame(5'd2, 0);
        cycle(1'b1);
        chk("post_rst_beats", 64'(beats_seen), 64'd2);
        chk("post_rst_fc", 64'(frame_cnt), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_count  = CNT_W'($urandom_range(0, 31));
            in_data   = rand_frame();
            out_ready = ($urandom_range(0, 9) < 7);
            cycle(1'b1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1);

        // 65536 empty frames wrap the counter with no beats.
        do_reset();
        ov_seen = 0;
        in_valid = 1'b1; in_count = 5'd0; out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) cycle(1'b0);
        chk("wrap_ffff", 64'(frame_cnt), 64'hFFFF);
        cycle(1'b1);
        chk("wrap_zero", 64'(frame_cnt), 64'd0);
        chk("wrap_no_beats", 64'(ov_seen), 64'd0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
